// File: rtl/mul32_pkg.sv
// mul32_pkg: shared FSM encoding and iteration/latency constants for the sequential multiplier.
package mul32_pkg;
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ABS  = 3'd1,
      S_RUN  = 3'd2,
      S_NEGL = 3'd3,
      S_NEGH = 3'd4,
      S_DONE = 3'd5
   } state_t;
   localparam int MUL_ITER    = 32;
   localparam int MUL_LATENCY = 35;
endpackage

// File: rtl/mul32_seq_adder32.sv
// Adder32: 32-bit ripple-style adder with carry in/out used for accumulate and negate.
module Adder32 (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cin,
   output logic [31:0] F,
   output logic        Cout
);
   assign {Cout, F} = {1'b0, A} + {1'b0, B} + {32'b0, Cin};
endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: sequential 32x32->64 signed/unsigned shift-add multiplier with start/done handshake.
module mul32_seq
   import mul32_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        Start,
   input  logic        Signed,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic        Done,
   output logic [63:0] P,
   output logic        ZF,
   output logic        SF
);
   state_t      state_q;
   logic [31:0] m_q, hi_q, lo_q;
   logic [4:0]  cnt_q;
   logic        sgn_q, neg_q, c_q;
   logic [31:0] u0_f, u1_f;
   logic        u0_c, u1_c;
   logic [32:0] acc_d;
   logic [63:0] res_d;
   // U0 doubles as the multiplicand negator in ABS, U1 negates the multiplier, then the product.
   Adder32 u0 (
      .A    (state_q == S_ABS ? ~m_q : hi_q),
      .B    (state_q == S_ABS ? 32'd0 : m_q),
      .Cin  (state_q == S_ABS),
      .F    (u0_f),
      .Cout (u0_c)
   );
   Adder32 u1 (
      .A    (~(state_q == S_NEGH ? hi_q : lo_q)),
      .B    (32'd0),
      .Cin  (state_q == S_NEGH ? c_q : 1'b1),
      .F    (u1_f),
      .Cout (u1_c)
   );
   always_comb begin
      acc_d = lo_q[0] ? {u0_c, u0_f} : {1'b0, hi_q};
      res_d = {neg_q ? u1_f : hi_q, lo_q};
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         P       <= 64'd0;
         ZF      <= 1'b0;
         SF      <= 1'b0;
         cnt_q   <= 5'd0;
         m_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         sgn_q   <= 1'b0;
         neg_q   <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               Done <= 1'b0;
               if (Start) begin
                  m_q     <= A;
                  lo_q    <= B;
                  sgn_q   <= Signed;
                  neg_q   <= Signed & (A[31] ^ B[31]);
                  Busy    <= 1'b1;
                  state_q <= S_ABS;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ABS: begin
               m_q     <= (sgn_q && m_q[31]) ? u0_f : m_q;
               lo_q    <= (sgn_q && lo_q[31]) ? u1_f : lo_q;
               hi_q    <= 32'd0;
               cnt_q   <= 5'd0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               {hi_q, lo_q} <= {acc_d, lo_q[31:1]};
               cnt_q        <= cnt_q + 5'd1;
               if (cnt_q == 5'(MUL_ITER - 1)) state_q <= S_NEGL;
            end
            S_NEGL: begin
               if (neg_q) {c_q, lo_q} <= {u1_c, u1_f};
               state_q <= S_NEGH;
            end
            S_NEGH: begin
               hi_q    <= res_d[63:32];
               P       <= res_d;
               ZF      <= (res_d == 64'd0);
               SF      <= res_d[63];
               Busy    <= 1'b0;
               Done    <= 1'b1;
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq: directed scoreboard bench for mul32_seq covering latency, sign handling, Start filtering and reset abort.
module tb_mul32_seq;
   import mul32_pkg::*;
   logic        CLK = 1'b0, RST = 1'b1, Start = 1'b0, Signed = 1'b0;
   logic [31:0] A = 32'd0, B = 32'd0;
   logic        Busy, Done, ZF, SF;
   logic [63:0] P;
   int          checks = 0, errors = 0, cyc = 0, t0 = 0, seen = 0;
   logic [65:0] sb[$];
   mul32_seq dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Signed(Signed), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .P(P), .ZF(ZF), .SF(SF)
   );
   always #5 CLK = ~CLK;
   function automatic logic [65:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb_, p;
      sa  = s ? {{32{a[31]}}, a} : {32'd0, a};
      sb_ = s ? {{32{b[31]}}, b} : {32'd0, b};
      p   = sa * sb_;
      return {p, p == 64'd0, p[63]};
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
      Signed = s;
      A      = a;
      B      = b;
      Start  = 1'b1;
      sb.push_back(model(s, a, b));
      tick();
      Start  = 1'b0;
      A      = $urandom;
      B      = $urandom;
      Signed = ~s;
      t0     = cyc;
      chk("busy_after_start", {63'd0, Busy}, 64'd1);
   endtask
   task automatic finish_op(input string tag);
      logic [65:0] e;
      while (!Done && cyc - t0 < 45) tick();
      chk({tag, "_latency"}, 64'(cyc - t0), 64'(MUL_LATENCY));
      chk({tag, "_busy_low"}, {63'd0, Busy}, 64'd0);
      e = (sb.size() != 0) ? sb.pop_front() : 66'h3_FFFF_FFFF_FFFF_FFFF;
      chk({tag, "_P"}, P, e[65:2]);
      chk({tag, "_ZF"}, {63'd0, ZF}, {63'd0, e[1]});
      chk({tag, "_SF"}, {63'd0, SF}, {63'd0, e[0]});
   endtask
   initial begin
      tick();
      tick();
      RST = 1'b0;
      chk("rst_busy", {63'd0, Busy}, 64'd0);
      chk("rst_done", {63'd0, Done}, 64'd0);
      chk("rst_P", P, 64'd0);
      chk("rst_flags", {62'd0, ZF, SF}, 64'd0);
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op("u_max");
      tick();
      chk("done_pulse_one_cycle", {63'd0, Done}, 64'd0);
      issue(1'b1, 32'hFFFF_FFFD, 32'd7);
      finish_op("s_m3x7");
      issue(1'b0, 32'hFFFF_FFFD, 32'd7);
      finish_op("u_m3x7");
      issue(1'b1, 32'h8000_0000, 32'h8000_0000);
      finish_op("s_min_min");
      issue(1'b1, 32'h8000_0000, 32'd1);
      finish_op("s_min_one");
      issue(1'b1, 32'd0, 32'hFFFF_FFFB);
      finish_op("s_zero_neg");
      issue(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (4) tick();
      {Start, Signed, A, B} = {1'b1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
      tick();
      Start = 1'b0;
      repeat (14) tick();
      {Start, Signed, A, B} = {1'b1, 1'b0, 32'h0000_0003, 32'h0000_0005};
      tick();
      Start = 1'b0;
      finish_op("ignore_start");
      issue(1'b0, 32'd1000, 32'd3000);
      finish_op("b2b_first");
      issue(1'b1, 32'hFFFF_FF00, 32'h0001_0001);
      finish_op("b2b_second");
      issue(1'b0, 32'hFFFF_0000, 32'h0000_FFFF);
      repeat (11) tick();
      {RST, Start} = 2'b11;
      tick();
      {RST, Start} = 2'b00;
      void'(sb.pop_back());
      chk("abort_busy", {63'd0, Busy}, 64'd0);
      chk("abort_P", P, 64'd0);
      chk("abort_flags", {62'd0, ZF, SF}, 64'd0);
      repeat (40) begin
         tick();
         seen += int'(Done);
      end
      chk("abort_no_done", 64'(seen), 64'd0);
      issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFF5);
      finish_op("after_abort");
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
